// File: rtl/vga_controller.sv
// vga_controller: 640x480 VGA timing generator driven by a 25 MHz pixel clock.
// The horizontal and vertical counters are exposed as x/y with zero latency.
// HS/VS/RGB come from a single output register stage, one cycle behind x/y/color.
// Optional feature macro: VGA_FRAME_TICK_EN adds the frame_tick output.
// frame_tick pulses once per frame, one cycle after the counters reach (0, V_VISIBLE).
module vga_controller #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        CLOCK_25,
  input  logic        RESET_N,
  input  logic [2:0]  color,
  output logic [11:0] x,
  output logic [11:0] y,
  output logic        video_active,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_R,
  output logic        VGA_G,
  output logic        VGA_B
`ifdef VGA_FRAME_TICK_EN
  ,
  output logic        frame_tick
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_VISIBLE);
  localparam logic [11:0] V_VIS    = 12'(V_VISIBLE);
  localparam logic [11:0] HS_START = 12'(H_VISIBLE + H_FRONT);
  localparam logic [11:0] HS_END   = 12'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [11:0] VS_START = 12'(V_VISIBLE + V_FRONT);
  localparam logic [11:0] VS_END   = 12'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [11:0] h_count_q, h_count_d;
  logic [11:0] v_count_q, v_count_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic [2:0]  rgb_q, rgb_d;

  assign x            = h_count_q;
  assign y            = v_count_q;
  assign video_active = (h_count_q < H_VIS) && (v_count_q < V_VIS);

  assign VGA_HS = hs_q;
  assign VGA_VS = vs_q;
  assign VGA_R  = rgb_q[2];
  assign VGA_G  = rgb_q[1];
  assign VGA_B  = rgb_q[0];

  // Next-state counters: h wraps every line, v advances only on the h wrap.
  always_comb begin
    h_count_d = h_count_q + 12'd1;
    v_count_d = v_count_q;
    if (h_count_q == H_LAST) begin
      h_count_d = 12'd0;
      if (v_count_q == V_LAST) begin
        v_count_d = 12'd0;
      end else begin
        v_count_d = v_count_q + 12'd1;
      end
    end
  end

  // Output stage inputs: active-low syncs, and colour forced to black while blanking.
  always_comb begin
    hs_d  = !((h_count_q >= HS_START) && (h_count_q <= HS_END));
    vs_d  = !((v_count_q >= VS_START) && (v_count_q <= VS_END));
    rgb_d = video_active ? color : 3'b000;
  end

  // Counters and registered outputs; reset parks the beam at (0,0) with syncs idle.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      h_count_q <= 12'd0;
      v_count_q <= 12'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rgb_q     <= 3'b000;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rgb_q     <= rgb_d;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic tick_q, tick_d;

  assign frame_tick = tick_q;

  // Frame pulse source: the first blanking line start, once per frame.
  always_comb begin
    tick_d = (h_count_q == 12'd0) && (v_count_q == V_VIS);
  end

  // Register the frame pulse so it lines up with HS/VS/RGB.
  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end
`endif

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller: scoreboard bench for vga_controller.
// The horizontal geometry is the real 800-clock line.
// The vertical geometry is shortened (19 lines per frame) so that whole frames fit in a short run.
// Sync widths are unchanged, so a frame still has 96-clock HS pulses and a 2-line (1600-clock) VS pulse.
module tb_vga_controller;

  localparam int TB_V_VISIBLE = 12;
  localparam int TB_V_FRONT   = 2;
  localparam int TB_V_SYNC    = 2;
  localparam int TB_V_BACK    = 3;
  localparam int TB_V_TOTAL   = TB_V_VISIBLE + TB_V_FRONT + TB_V_SYNC + TB_V_BACK;
  localparam int TB_H_TOTAL   = 800;
  localparam int FRAME_CYCLES = TB_H_TOTAL * TB_V_TOTAL;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic        act;
    logic        hs;
    logic        vs;
    logic [2:0]  rgb;
    logic        tick;
  } exp_t;

  logic        CLOCK_25;
  logic        RESET_N;
  logic [2:0]  color;
  logic [11:0] x;
  logic [11:0] y;
  logic        video_active;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_R;
  logic        VGA_G;
  logic        VGA_B;
`ifdef VGA_FRAME_TICK_EN
  logic        frame_tick;
`endif

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int   mh = 0;
  int   mv = 0;

  logic count_en = 1'b0;
  int   hs_lows  = 0;
  int   vs_lows  = 0;
  int   step_idx = 0;
  int   tick_steps[$];

  vga_controller #(
    .V_VISIBLE (TB_V_VISIBLE),
    .V_FRONT   (TB_V_FRONT),
    .V_SYNC    (TB_V_SYNC),
    .V_BACK    (TB_V_BACK)
  ) dut (
    .CLOCK_25     (CLOCK_25),
    .RESET_N      (RESET_N),
    .color        (color),
    .x            (x),
    .y            (y),
    .video_active (video_active),
    .VGA_HS       (VGA_HS),
    .VGA_VS       (VGA_VS),
    .VGA_R        (VGA_R),
    .VGA_G        (VGA_G),
    .VGA_B        (VGA_B)
`ifdef VGA_FRAME_TICK_EN
    ,
    .frame_tick   (frame_tick)
`endif
  );

  // 25 MHz pixel clock.
  initial CLOCK_25 = 1'b0;
  always #20 CLOCK_25 = ~CLOCK_25;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_active(input int h, input int v);
    return (h < 640) && (v < TB_V_VISIBLE);
  endfunction

  // Directed colour rule: the two spec points get fixed colours, elsewhere a position pattern.
  function automatic logic [2:0] pickColor(input int h, input int v);
    if (h == 10 && v == 10) return 3'b101;
    if (h == 640) return 3'b111;
    return 3'((h + 3 * v) % 8);
  endfunction

  // One clock of stimulus; the expected sample at the next negedge goes into the scoreboard.
  task automatic applyStimulus(input logic [2:0] c, input logic rst_n_in);
    exp_t e;
    @(negedge CLOCK_25);
    #2;
    step_idx++;
    if (count_en) begin
      if (!VGA_HS) hs_lows++;
      if (!VGA_VS) vs_lows++;
`ifdef VGA_FRAME_TICK_EN
      if (frame_tick) tick_steps.push_back(step_idx);
`endif
    end
    color   = c;
    RESET_N = rst_n_in;
    if (!rst_n_in) begin
      mh     = 0;
      mv     = 0;
      e.x    = 12'd0;
      e.y    = 12'd0;
      e.act  = 1'b1;
      e.hs   = 1'b1;
      e.vs   = 1'b1;
      e.rgb  = 3'b000;
      e.tick = 1'b0;
    end else begin
      e.hs   = !(mh >= 656 && mh <= 751);
      e.vs   = !(mv >= TB_V_VISIBLE + TB_V_FRONT && mv <= TB_V_VISIBLE + TB_V_FRONT + TB_V_SYNC - 1);
      e.rgb  = model_active(mh, mv) ? c : 3'b000;
      e.tick = (mh == 0) && (mv == TB_V_VISIBLE);
      if (mh == TB_H_TOTAL - 1) begin
        mh = 0;
        mv = (mv == TB_V_TOTAL - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      e.x   = 12'(mh);
      e.y   = 12'(mv);
      e.act = model_active(mh, mv);
    end
    sb.push_back(e);
  endtask

  task automatic runTo(input int th, input int tv);
    for (int i = 0; i < 2 * FRAME_CYCLES; i++) begin
      if (mh == th && mv == tv) break;
      applyStimulus(pickColor(mh, mv), 1'b1);
    end
    checkOutput("reach_position", 32'((mh == th) && (mv == tv)), 32'd1);
  endtask

  // Monitor: each negedge, pop the pending expectation and compare every output.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLOCK_25);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("x", 32'(x), 32'(e.x));
        checkOutput("y", 32'(y), 32'(e.y));
        checkOutput("video_active", 32'(video_active), 32'(e.act));
        checkOutput("VGA_HS", 32'(VGA_HS), 32'(e.hs));
        checkOutput("VGA_VS", 32'(VGA_VS), 32'(e.vs));
        checkOutput("RGB", 32'({VGA_R, VGA_G, VGA_B}), 32'(e.rgb));
`ifdef VGA_FRAME_TICK_EN
        checkOutput("frame_tick", 32'(frame_tick), 32'(e.tick));
`endif
      end
    end
  end

  // Directed sequence: reset, one counted line, mid-frame resets, then full frames.
  initial begin
    RESET_N = 1'b0;
    color   = 3'b000;

    for (int i = 0; i < 3; i++) applyStimulus(3'b000, 1'b0);

    applyStimulus(pickColor(mh, mv), 1'b1);
    hs_lows  = 0;
    count_en = 1'b1;
    for (int i = 0; i < TB_H_TOTAL; i++) applyStimulus(pickColor(mh, mv), 1'b1);
    count_en = 1'b0;
    checkOutput("hs_low_per_line", 32'(hs_lows), 32'd96);

    runTo(300, 5);
    applyStimulus(3'b111, 1'b0);
    for (int i = 0; i < 50; i++) applyStimulus(pickColor(mh, mv), 1'b1);

    runTo(100, 3);
    for (int i = 0; i < 5; i++) applyStimulus(3'b111, 1'b0);

    applyStimulus(pickColor(mh, mv), 1'b1);
    vs_lows  = 0;
    count_en = 1'b1;
    for (int i = 0; i < FRAME_CYCLES; i++) applyStimulus(pickColor(mh, mv), 1'b1);
    checkOutput("vs_low_per_frame", 32'(vs_lows), 32'd1600);
    for (int i = 0; i < 9700; i++) applyStimulus(pickColor(mh, mv), 1'b1);
    count_en = 1'b0;

`ifdef VGA_FRAME_TICK_EN
    checkOutput("tick_count", 32'(tick_steps.size()), 32'd2);
    if (tick_steps.size() == 2) begin
      checkOutput("tick_spacing", 32'(tick_steps[1] - tick_steps[0]), 32'(FRAME_CYCLES));
    end
`endif

    @(negedge CLOCK_25);
    #1;
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
